calc_sequencer: RTL and testbench

Control FSM that sequences the calculator datapath: conditions raw push-buttons, latches operands and the ALU function, and issues one ALU operation per execute press. It owns the 16-bit accumulator, the status flags and the LED register, and drives an external 32-bit ALU through explicit operand/opcode ports. It sits between the board I/O and the existing ALU.

---
 rtl/calc_pkg.sv | 35 +++
 rtl/calc_sequencer_btn_conditioner.sv | 64 ++++++
 rtl/calc_sequencer.sv | 139 +++++++++++++
 tb/tb_calc_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: ALU opcodes, the button-select
// to opcode map and the sequencer state encoding.
package calc_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  // Unassigned select codes fall back to ADD so every button combination does something.
  function automatic logic [3:0] op_map(input logic [2:0] sel);
    case (sel)
      3'b000:  return ALU_AND;
      3'b001:  return ALU_OR;
      3'b010:  return ALU_ADD;
      3'b011:  return ALU_SUB;
      3'b100:  return ALU_SLT;
      3'b101:  return ALU_NOR;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/calc_sequencer_btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, optional debounce (CALC_DEBOUNCE_EN)
// and a rising-edge detector producing a one-cycle pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic held;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;
  logic            accepted;

  // Any return to the accepted level restarts the stability count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      accepted <= 1'b0;
    end else if (sync == accepted) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      accepted <= sync;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = accepted;
`else
  assign level = sync;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) held <= 1'b0;
    else        held <= level;
  end

  assign rise = level & ~held;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control sequencer: conditions buttons, latches ALU operands and
// writes the ALU result back into the accumulator. Optional debounce: CALC_DEBOUNCE_EN.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int ALU_LAT         = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btnl,
  input  logic        btnc,
  input  logic        btnr,
  input  logic        btnd,
  input  logic        btnu,
  input  logic [15:0] sw,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [15:0] acc,
  output logic [15:0] led,
  output logic        busy,
  output logic        ovf,
  output logic        zero_flag
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  if (ALU_LAT < 1) begin : g_bad_alu_lat
    $error("calc_sequencer: ALU_LAT must be at least 1");
  end

  logic [2:0] sel;
  logic [2:0] sel_rise_unused;
  logic [1:0] ctl_level_unused;
  logic       exec_rise;
  logic       clr_rise;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnl (
    .clk(clk), .rst_n(rst_n), .raw(btnl), .level(sel[2]), .rise(sel_rise_unused[2])
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnc (
    .clk(clk), .rst_n(rst_n), .raw(btnc), .level(sel[1]), .rise(sel_rise_unused[1])
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnr (
    .clk(clk), .rst_n(rst_n), .raw(btnr), .level(sel[0]), .rise(sel_rise_unused[0])
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnd (
    .clk(clk), .rst_n(rst_n), .raw(btnd), .level(ctl_level_unused[0]), .rise(exec_rise)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnu (
    .clk(clk), .rst_n(rst_n), .raw(btnu), .level(ctl_level_unused[1]), .rise(clr_rise)
  );

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load_ops;
  logic             write_back;
  logic             clear_acc;

  // Clear has priority over execute in every state; it also aborts an operation in flight.
  always_comb begin
    state_nxt  = state;
    load_ops   = 1'b0;
    write_back = 1'b0;
    clear_acc  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_rise) begin
          clear_acc = 1'b1;
        end else if (exec_rise) begin
          load_ops  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (clr_rise) begin
          clear_acc = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = WB;
        end
      end
      WB: begin
        if (clr_rise) begin
          clear_acc = 1'b1;
        end else begin
          write_back = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      led       <= '0;
      ovf       <= 1'b0;
      zero_flag <= 1'b0;
      alu_op    <= ALU_AND;
      alu_op1   <= '0;
      alu_op2   <= '0;
      cnt       <= '0;
    end else begin
      led <= acc;
      if (clear_acc) begin
        acc       <= '0;
        ovf       <= 1'b0;
        zero_flag <= 1'b0;
      end else if (write_back) begin
        acc       <= alu_result[15:0];
        ovf       <= (alu_result[31:16] != {16{alu_result[15]}});
        zero_flag <= alu_zero;
      end
      if (load_ops) begin
        alu_op1 <= sext16(acc);
        alu_op2 <= sext16(sw);
        alu_op  <= op_map(sel);
        cnt     <= CNT_LOAD;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: two instances (ALU_LAT=1 and 3) share the
// button stimulus and are compared against an arithmetic accumulator model.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnl = 1'b0, btnc = 1'b0, btnr = 1'b0, btnd = 1'b0, btnu = 1'b0;
  logic [15:0] sw = '0;

  logic [3:0]  alu_op, alu_op_3;
  logic [31:0] alu_op1, alu_op2, alu_result, alu_op1_3, alu_op2_3, alu_result_3;
  logic        alu_zero, alu_zero_3;
  logic [15:0] acc, led, acc_3, led_3;
  logic        busy, ovf, zero_flag, busy_3, ovf_3, zero_flag_3;

  always #5 clk = ~clk;

  // Behavioural ALU standing in for the external 32-bit ALU.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result   = alu_f(alu_op, alu_op1, alu_op2);
  assign alu_zero     = (alu_result == 32'd0);
  assign alu_result_3 = alu_f(alu_op_3, alu_op1_3, alu_op2_3);
  assign alu_zero_3   = (alu_result_3 == 32'd0);

  calc_sequencer #(.ALU_LAT(1), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .btnl(btnl), .btnc(btnc), .btnr(btnr), .btnd(btnd), .btnu(btnu),
    .sw(sw), .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
    .alu_zero(alu_zero), .acc(acc), .led(led), .busy(busy), .ovf(ovf), .zero_flag(zero_flag)
  );

  calc_sequencer #(.ALU_LAT(3), .DEBOUNCE_CYCLES(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .btnl(btnl), .btnc(btnc), .btnr(btnr), .btnd(btnd), .btnu(btnu),
    .sw(sw), .alu_op(alu_op_3), .alu_op1(alu_op1_3), .alu_op2(alu_op2_3), .alu_result(alu_result_3),
    .alu_zero(alu_zero_3), .acc(acc_3), .led(led_3), .busy(busy_3), .ovf(ovf_3), .zero_flag(zero_flag_3)
  );

  int          tests = 0;
  int          fails = 0;
  logic [15:0] acc_m = '0;
  logic        ovf_m = 1'b0;
  logic        zero_m = 1'b0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Reference: 16-bit signed operands combined with integer arithmetic.
  task automatic model_op(input logic [2:0] s, input logic [15:0] b);
    int r;
    if (s == 3'b011) r = int'($signed(acc_m)) - int'($signed(b));
    else             r = int'($signed(acc_m)) + int'($signed(b));
    ovf_m  = (r > 32767) || (r < -32768);
    zero_m = (r == 0);
    acc_m  = r[15:0];
  endtask

  task automatic press_exec(input logic [2:0] s, input logic [15:0] v);
    {btnl, btnc, btnr} = s;
    sw   = v;
    btnd = 1'b1;
    tick(3);
    btnd = 1'b0;
    tick(8);
    model_op(s, v);
  endtask

  task automatic press_clr();
    btnu = 1'b1;
    tick(3);
    btnu = 1'b0;
    tick(4);
    acc_m  = '0;
    ovf_m  = 1'b0;
    zero_m = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    tests++; if (acc !== 16'h0) begin fails++; $display("FAIL reset_acc got=%h exp=0000", acc); end
    tests++; if (led !== 16'h0) begin fails++; $display("FAIL reset_led got=%h exp=0000", led); end
    tests++; if (alu_op !== 4'b0000) begin fails++; $display("FAIL reset_alu_op got=%b exp=0000", alu_op); end
    tests++; if ({alu_op1, alu_op2} !== 64'h0) begin fails++; $display("FAIL reset_operands got=%h %h exp=0", alu_op1, alu_op2); end
    tests++; if ({busy, ovf, zero_flag} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b exp=000", {busy, ovf, zero_flag}); end
    tests++; if ({acc_3, busy_3} !== 17'h0) begin fails++; $display("FAIL reset_dut3 got=%h %b exp=0", acc_3, busy_3); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_add_overflow();
    press_clr();
    press_exec(3'b010, 16'h7FFF);
    {btnl, btnc, btnr} = 3'b010;
    sw   = 16'h0001;
    btnd = 1'b1;
    tick(1);
    btnd = 1'b0;
    tick(1);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ovf_busy_e2 got=%b exp=0", busy); end
    tick(1);
    tests++; if (alu_op !== 4'b0010) begin fails++; $display("FAIL ovf_alu_op got=%b exp=0010", alu_op); end
    tests++; if ({alu_op1, alu_op2} !== {32'h0000_7FFF, 32'h0000_0001}) begin
      fails++; $display("FAIL ovf_operands got=%h %h exp=00007fff 00000001", alu_op1, alu_op2); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ovf_busy_e3 got=%b exp=1", busy); end
    tick(1);
    tests++; if (acc !== 16'h7FFF) begin fails++; $display("FAIL ovf_acc_e4 got=%h exp=7fff", acc); end
    tick(1);
    tests++; if (acc !== 16'h8000) begin fails++; $display("FAIL ovf_acc_e5 got=%h exp=8000", acc); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    tests++; if (led !== 16'h7FFF) begin fails++; $display("FAIL ovf_led_e5 got=%h exp=7fff", led); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ovf_busy_e5 got=%b exp=0", busy); end
    tick(1);
    tests++; if (led !== 16'h8000) begin fails++; $display("FAIL ovf_led_e6 got=%h exp=8000", led); end
    model_op(3'b010, 16'h0001);
    tick(4);
    tests++; if ({acc_3, ovf_3} !== {acc_m, ovf_m}) begin
      fails++; $display("FAIL ovf_dut3 got=%h/%b exp=%h/%b", acc_3, ovf_3, acc_m, ovf_m); end
  endtask

  task automatic test_sub_zero();
    press_clr();
    press_exec(3'b010, 16'h0005);
    press_exec(3'b011, 16'h0005);
    tests++; if (alu_op !== 4'b0110) begin fails++; $display("FAIL sub_alu_op got=%b exp=0110", alu_op); end
    tests++; if ({acc, zero_flag, ovf} !== {acc_m, zero_m, ovf_m} || acc_m !== 16'h0) begin
      fails++; $display("FAIL sub_zero got=%h/z%b/o%b exp=0000/z1/o0", acc, zero_flag, ovf); end
    tests++; if ({acc_3, zero_flag_3, ovf_3} !== {16'h0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sub_zero_dut3 got=%h/z%b/o%b exp=0000/z1/o0", acc_3, zero_flag_3, ovf_3); end
  endtask

  task automatic test_sub_wrap();
    press_clr();
    press_exec(3'b010, 16'h8000);
    tests++; if ({acc, ovf} !== {16'h8000, 1'b0}) begin fails++; $display("FAIL min_load got=%h/%b exp=8000/0", acc, ovf); end
    press_exec(3'b011, 16'h0001);
    tests++; if ({acc, ovf, zero_flag} !== {acc_m, ovf_m, zero_m}) begin
      fails++; $display("FAIL sub_wrap got=%h/%b/%b exp=%h/%b/%b", acc, ovf, zero_flag, acc_m, ovf_m, zero_m); end
  endtask

  task automatic test_held_exec();
    int nb, nb3;
    press_clr();
    {btnl, btnc, btnr} = 3'b010;
    sw   = 16'h0003;
    btnd = 1'b1;
    nb = 0; nb3 = 0;
    for (int i = 0; i < 26; i++) begin
      if (i == 20) btnd = 1'b0;
      tick(1);
      nb  += int'(busy);
      nb3 += int'(busy_3);
    end
    model_op(3'b010, 16'h0003);
    tests++; if (acc !== 16'h0003) begin fails++; $display("FAIL held_acc got=%h exp=0003", acc); end
    tests++; if (nb !== 2) begin fails++; $display("FAIL held_busy_cycles got=%0d exp=2", nb); end
    tests++; if ({acc_3, nb3} !== {16'h0003, 32'd4}) begin fails++; $display("FAIL held_dut3 got=%h/%0d exp=0003/4", acc_3, nb3); end
  endtask

  task automatic test_clr_wins();
    logic saw_busy;
    press_clr();
    press_exec(3'b010, 16'h1234);
    tests++; if (acc !== 16'h1234) begin fails++; $display("FAIL clrwin_setup got=%h exp=1234", acc); end
    saw_busy = 1'b0;
    btnu = 1'b1;
    btnd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) begin btnu = 1'b0; btnd = 1'b0; end
      tick(1);
      saw_busy |= busy | busy_3;
    end
    acc_m = '0; ovf_m = 1'b0; zero_m = 1'b0;
    tests++; if (saw_busy !== 1'b0) begin fails++; $display("FAIL clrwin_busy got=%b exp=0", saw_busy); end
    tests++; if ({acc, acc_3} !== 32'h0) begin fails++; $display("FAIL clrwin_acc got=%h %h exp=0000 0000", acc, acc_3); end
  endtask

  task automatic test_reset_mid_exec();
    press_clr();
    press_exec(3'b010, 16'h0007);
    {btnl, btnc, btnr} = 3'b010;
    sw   = 16'h0009;
    btnd = 1'b1;
    tick(1);
    btnd = 1'b0;
    tick(2);
    tests++; if ({busy, busy_3} !== 2'b11) begin fails++; $display("FAIL rstmid_in_exec got=%b exp=11", {busy, busy_3}); end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    acc_m = '0; ovf_m = 1'b0; zero_m = 1'b0;
    tests++; if ({busy, acc, led} !== 33'h0) begin fails++; $display("FAIL rstmid_after got=%b/%h/%h exp=0/0000/0000", busy, acc, led); end
    tick(6);
    tests++; if ({busy, busy_3, acc, acc_3} !== 34'h0) begin
      fails++; $display("FAIL rstmid_no_wb got=%b%b/%h/%h exp=00/0000/0000", busy, busy_3, acc, acc_3); end
  endtask

  task automatic test_lat3();
    int nb3;
    press_clr();
    press_exec(3'b010, 16'h0002);
    {btnl, btnc, btnr} = 3'b010;
    sw   = 16'hFFFF;
    btnd = 1'b1;
    nb3  = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 1) btnd = 1'b0;
      nb3 += int'(busy_3);
      tests++; if (busy_3 !== (k >= 3 && k <= 6)) begin fails++; $display("FAIL lat3_busy_e%0d got=%b exp=%b", k, busy_3, (k >= 3 && k <= 6)); end
      if (k == 3) begin
        tests++; if (alu_op2_3 !== 32'hFFFF_FFFF) begin fails++; $display("FAIL lat3_sext got=%h exp=ffffffff", alu_op2_3); end
      end
      if (k == 6) begin
        tests++; if (acc_3 !== 16'h0002) begin fails++; $display("FAIL lat3_acc_e6 got=%h exp=0002", acc_3); end
      end
      if (k == 7) begin
        tests++; if (acc_3 !== 16'h0001) begin fails++; $display("FAIL lat3_acc_e7 got=%h exp=0001", acc_3); end
      end
    end
    model_op(3'b010, 16'hFFFF);
    tick(3);
    tests++; if (nb3 !== 4) begin fails++; $display("FAIL lat3_busy_cycles got=%0d exp=4", nb3); end
    tests++; if ({acc, ovf} !== {acc_m, ovf_m}) begin fails++; $display("FAIL lat3_dut1 got=%h/%b exp=%h/%b", acc, ovf, acc_m, ovf_m); end
  endtask

  task automatic test_random();
    logic [2:0]  s;
    logic [15:0] v;
    press_clr();
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 4) == 0) press_clr();
      s = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'b010;
      v = 16'($urandom);
      press_exec(s, v);
      tests++; if ({acc, ovf, zero_flag, led} !== {acc_m, ovf_m, zero_m, acc_m}) begin
        fails++; $display("FAIL rand%0d_dut1 sel=%b sw=%h got=%h/%b/%b led=%h exp=%h/%b/%b", i, s, v, acc, ovf, zero_flag, led, acc_m, ovf_m, zero_m); end
      tests++; if ({acc_3, ovf_3, zero_flag_3, led_3} !== {acc_m, ovf_m, zero_m, acc_m}) begin
        fails++; $display("FAIL rand%0d_dut3 sel=%b sw=%h got=%h/%b/%b exp=%h/%b/%b", i, s, v, acc_3, ovf_3, zero_flag_3, acc_m, ovf_m, zero_m); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_sub_wrap();
    test_held_exec();
    test_clr_wins();
    test_reset_mid_exec();
    test_lat3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
